// File: rtl/event_window_ctrl.sv
// Event window sequencer: counts event_in pulses over a win_len-cycle window and
// returns the count on a valid/ready result port. Optional macro: EVENT_WINDOW_SAT_EN.
module event_window_ctrl #(
  parameter int CW = 8,
  parameter int WW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [WW-1:0] win_len,
  input  logic          abort,
  input  logic          event_in,
  output logic          busy,
  output logic          cnt_en,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [CW-1:0] res_count,
  output logic          res_ovf
);

  // Result handshake: a result is transferred on any posedge where
  // res_valid & res_ready; res_count/res_ovf are stable while res_valid is high.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [WW-1:0] W_ONE = WW'(1);

  state_t        state;
  logic [WW-1:0] remaining;
  logic [CW-1:0] count;
  logic          ovf;
  logic [CW-1:0] count_nxt;
  logic          ovf_nxt;

  assign cnt_en = event_in & (state == COUNT);

  // Next count including this cycle's event, so the last window cycle is counted.
  always_comb begin
    count_nxt = count;
    ovf_nxt   = ovf;
    if (event_in) begin
      if (&count) begin
        ovf_nxt = 1'b1;
`ifdef EVENT_WINDOW_SAT_EN
        count_nxt = count;
`else
        count_nxt = '0;
`endif
      end else begin
        count_nxt = count + C_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_count <= '0;
      res_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (win_len != '0) begin
              state     <= COUNT;
              remaining <= win_len;
              count     <= '0;
              ovf       <= 1'b0;
            end else begin
              state     <= HOLD;
              res_valid <= 1'b1;
              res_count <= '0;
              res_ovf   <= 1'b0;
            end
          end
        end
        COUNT: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            count     <= count_nxt;
            ovf       <= ovf_nxt;
            remaining <= remaining - W_ONE;
            if (remaining == W_ONE) begin
              state     <= HOLD;
              res_valid <= 1'b1;
              res_count <= count_nxt;
              res_ovf   <= ovf_nxt;
            end
          end
        end
        HOLD: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_event_window_ctrl.sv
// Directed bench for event_window_ctrl: windows, zero-length window, overflow,
// abort, late start requests and async reset, all with hand-computed expectations.
module tb_event_window_ctrl;

  localparam int CW = 8;
  localparam int WW = 16;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [WW-1:0] win_len;
  logic          abort;
  logic          event_in;
  logic          busy;
  logic          cnt_en;
  logic          res_valid;
  logic          res_ready;
  logic [CW-1:0] res_count;
  logic          res_ovf;

  int total;
  int bad;

  event_window_ctrl #(.CW(CW), .WW(WW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .win_len   (win_len),
    .abort     (abort),
    .event_in  (event_in),
    .busy      (busy),
    .cnt_en    (cnt_en),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_count (res_count),
    .res_ovf   (res_ovf)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs then change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  int        valid_seen;
  logic [7:0] ovf_exp_count;

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    start = 1'b0;
    win_len = '0;
    abort = 1'b0;
    event_in = 1'b0;
    res_ready = 1'b0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_valid", res_valid, 0);
    check("rst_count", res_count, 0);
    check("rst_ovf", res_ovf, 0);
    rst_n = 1'b1;
    tick();

    // 10-cycle window, events on COUNT cycles 2,3,5,7 -> 4
    start = 1'b1;
    win_len = 16'd10;
    tick();
    start = 1'b0;
    win_len = 16'd3;
    for (int k = 1; k <= 10; k++) begin
      event_in = (k == 2 || k == 3 || k == 5 || k == 7);
      start = (k == 4);
      #1;
      check("w10_cnt_en", cnt_en, event_in);
      check("w10_busy", busy, 1);
      check("w10_valid_low", res_valid, 0);
      tick();
    end
    event_in = 1'b1;
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("w10_valid", res_valid, 1);
      check("w10_count", res_count, 4);
      check("w10_ovf", res_ovf, 0);
      check("hold_cnt_en", cnt_en, 0);
      tick();
    end
    // start during the handshake cycle must be ignored
    win_len = 16'd0;
    handshake();
    check("hs_valid", res_valid, 0);
    check("hs_busy", busy, 0);
    check("idle_keep_count", res_count, 4);
    start = 1'b0;
    event_in = 1'b0;
    tick();
    check("hs_start_ignored", busy, 0);

    // async reset in the middle of a window
    start = 1'b1;
    win_len = 16'd50;
    tick();
    start = 1'b0;
    event_in = 1'b1;
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", res_valid, 0);
    check("mid_rst_count", res_count, 0);
    check("mid_rst_cnt_en", cnt_en, 0);
    event_in = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
    repeat (52) tick();
    check("post_rst_idle", busy, 0);

    // zero-length window
    start = 1'b1;
    win_len = 16'd0;
    event_in = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b1;
    #1;
    check("w0_valid", res_valid, 1);
    check("w0_count", res_count, 0);
    check("w0_busy", busy, 1);
    check("w0_cnt_en", cnt_en, 0);
    tick();
    check("hold_abort_ignored", res_valid, 1);
    abort = 1'b0;
    event_in = 1'b0;
    handshake();
    check("w0_done", busy, 0);

    // 300-cycle window, events every cycle -> overflow
    start = 1'b1;
    win_len = 16'd300;
    tick();
    start = 1'b0;
    event_in = 1'b1;
    repeat (299) tick();
    check("w300_not_yet", res_valid, 0);
    tick();
    event_in = 1'b0;
`ifdef EVENT_WINDOW_SAT_EN
    ovf_exp_count = 8'd255;
`else
    ovf_exp_count = 8'd44;
`endif
    check("w300_valid", res_valid, 1);
    check("w300_ovf", res_ovf, 1);
    check("w300_count", res_count, ovf_exp_count);
    handshake();

    // event on last window cycle and on the first HOLD cycle -> counted once
    start = 1'b1;
    win_len = 16'd4;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      event_in = (k == 4);
      #1;
      check("last_cnt_en", cnt_en, event_in);
      tick();
    end
    #1;
    check("after_cnt_en", cnt_en, 0);
    tick();
    event_in = 1'b0;
    check("last_count", res_count, 1);
    check("last_ovf", res_ovf, 0);
    handshake();

    // abort coinciding with the final window cycle wins
    start = 1'b1;
    win_len = 16'd3;
    tick();
    start = 1'b0;
    event_in = 1'b1;
    repeat (2) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    event_in = 1'b0;
    check("abort_last_busy", busy, 0);
    check("abort_last_valid", res_valid, 0);
    check("abort_last_keep", res_count, 1);

    // 20-cycle window, start ignored mid-window, abort on cycle 5
    start = 1'b1;
    win_len = 16'd20;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      start = (k == 2);
      win_len = 16'd0;
      event_in = 1'b1;
      tick();
      check("w20_busy", busy, 1);
      check("w20_no_valid", res_valid, 0);
    end
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    event_in = 1'b0;
    check("abort_busy", busy, 0);
    valid_seen = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (res_valid) valid_seen++;
    end
    check("abort_no_result", valid_seen, 0);
    check("abort_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
